// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises N_SRC async request lines, latches rising edges as
//   pending events, masks them, picks the lowest index, and emits one pulse per event.
// Latency: pending SYNC_STAGES clocks after the first sampling edge; pulse one clock later.
// Backpressure: no new pulse until i_eoi closes the current SERVICE; edges keep latching.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_irq[N_SRC]          asynchronous request lines, rising-edge triggered
//   i_mask[N_SRC]         1 = source blocked from dispatch (still latches pending)
//   i_eoi                 end-of-interrupt strobe, honoured only in SERVICE
//   o_interrupt           single-cycle dispatch pulse
//   o_irq_id[ID_W]        id of the most recently dispatched source
//   o_pending[N_SRC]      current pending bits
//   o_busy                high while a dispatched interrupt awaits i_eoi
module interrupt_controller #(
    parameter int N_SRC       = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_SRC-1:0] i_irq,
    input  logic [N_SRC-1:0] i_mask,
    input  logic             i_eoi,
    output logic             o_interrupt,
    output logic [ID_W-1:0]  o_irq_id,
    output logic [N_SRC-1:0] o_pending,
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FIRE    = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [1:0]       r_state;
    logic [N_SRC-1:0] r_sync [SYNC_STAGES];
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pending;
    logic [ID_W-1:0]  r_irq_id;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_clr;
    logic [ID_W-1:0]  w_win_id;

    // Synchroniser chain plus one history flop for rising-edge detection.
    // Everything resets to 0, so a line already high at release counts as an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_irq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_eligible = r_pending & ~i_mask;

    // Fixed priority: scanning downwards leaves the lowest eligible index.
    always_comb begin
        w_win_id = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_win_id = ID_W'(k);
            end
        end
    end

    // The dispatched source is cleared during FIRE.
    always_comb begin
        w_clr = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_clr[k] = (r_state == S_FIRE) && (r_irq_id == ID_W'(k));
        end
    end

    // Edge is OR-ed in after the clear so a new event on the firing source survives.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_irq_id <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_eligible) begin
                        r_irq_id <= w_win_id;
                        r_state  <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    r_state <= S_SERVICE;
                end
                S_SERVICE: begin
                    if (i_eoi) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs come from registered state only.
    assign o_interrupt = (r_state == S_FIRE);
    assign o_busy      = (r_state == S_SERVICE);
    assign o_irq_id    = r_irq_id;
    assign o_pending   = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scenarios with literal expectations, then random
// request/mask/eoi/reset traffic compared every cycle against a behavioural model.
module tb_interrupt_controller;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int S   = 2;

    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic [N-1:0]   irq  = '0;
    logic [N-1:0]   mask = '0;
    logic           eoi  = 1'b0;

    logic           dut_int;
    logic [IDW-1:0] dut_id;
    logic [N-1:0]   dut_pend;
    logic           dut_busy;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_controller #(
        .N_SRC       (N),
        .ID_W        (IDW),
        .SYNC_STAGES (S)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_irq       (irq),
        .i_mask      (mask),
        .i_eoi       (eoi),
        .o_interrupt (dut_int),
        .o_irq_id    (dut_id),
        .o_pending   (dut_pend),
        .o_busy      (dut_busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_hist[j] = request lines sampled j clock edges ago (j = 0 is this edge).
    logic [N-1:0]   m_hist [S+2] = '{default: '0};
    logic [N-1:0]   m_pend = '0;
    logic           m_fire = 1'b0;
    logic           m_busy = 1'b0;
    logic [IDW-1:0] m_id   = '0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < S + 2; j++) m_hist[j] = '0;
            m_pend = '0;
            m_fire = 1'b0;
            m_busy = 1'b0;
            m_id   = '0;
        end else begin
            logic [N-1:0] ev;
            logic [N-1:0] elig;
            for (int j = S + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = irq;
            // A rising edge becomes visible S edges after it was first sampled.
            ev   = m_hist[S] & ~m_hist[S+1];
            elig = m_pend & ~mask;
            if (m_fire) begin
                m_pend[m_id] = 1'b0;
                m_pend       = m_pend | ev;
                m_fire       = 1'b0;
                m_busy       = 1'b1;
            end else begin
                if (m_busy) begin
                    if (eoi) m_busy = 1'b0;
                end else if (elig != '0) begin
                    m_id   = IDW'(lowest(elig));
                    m_fire = 1'b1;
                end
                m_pend = m_pend | ev;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if ({dut_int, dut_busy, dut_id, dut_pend} !== {m_fire, m_busy, m_id, m_pend}) begin
                n_err++;
                $display("FAIL model t=%0t: got int=%b busy=%b id=%0d pend=%b, want int=%b busy=%b id=%0d pend=%b",
                         $time, dut_int, dut_busy, dut_id, dut_pend, m_fire, m_busy, m_id, m_pend);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string nm, input logic i, input logic b,
                             input logic [IDW-1:0] id, input logic [N-1:0] p);
        n_cmp++;
        if ({dut_int, dut_busy, dut_id, dut_pend} !== {i, b, id, p}) begin
            n_err++;
            $display("FAIL %s: got int=%b busy=%b id=%0d pend=%b, want int=%b busy=%b id=%0d pend=%b",
                     nm, dut_int, dut_busy, dut_id, dut_pend, i, b, id, p);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        check_out("reset", 1'b0, 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;

        // Single source
        irq = 4'b0100;
        step(3);
        check_out("single_pend", 1'b0, 1'b0, 2'd0, 4'b0100);
        step(1);
        check_out("single_fire", 1'b1, 1'b0, 2'd2, 4'b0100);
        step(1);
        check_out("single_busy", 1'b0, 1'b1, 2'd2, 4'b0000);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        check_out("single_eoi", 1'b0, 1'b0, 2'd2, 4'b0000);
        step(5);
        check_out("single_quiet", 1'b0, 1'b0, 2'd2, 4'b0000);

        // Priority: sources 3 and 1 together
        irq = 4'b0000;
        step(3);
        irq = 4'b1010;
        step(3);
        check_out("prio_pend", 1'b0, 1'b0, 2'd2, 4'b1010);
        step(1);
        check_out("prio_fire1", 1'b1, 1'b0, 2'd1, 4'b1010);
        step(1);
        check_out("prio_svc1", 1'b0, 1'b1, 2'd1, 4'b1000);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        check_out("prio_idle", 1'b0, 1'b0, 2'd1, 4'b1000);
        step(1);
        check_out("prio_fire2", 1'b1, 1'b0, 2'd3, 4'b1000);
        step(1);
        check_out("prio_svc2", 1'b0, 1'b1, 2'd3, 4'b0000);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;

        // Mask holds a pending source off; unmask dispatches it
        irq = 4'b0000;
        step(3);
        mask = 4'b0001;
        irq  = 4'b0001;
        step(3);
        check_out("mask_pend", 1'b0, 1'b0, 2'd3, 4'b0001);
        step(20);
        check_out("mask_hold", 1'b0, 1'b0, 2'd3, 4'b0001);
        mask = 4'b0000;
        step(1);
        check_out("unmask_fire", 1'b1, 1'b0, 2'd0, 4'b0001);
        step(1);
        check_out("unmask_svc", 1'b0, 1'b1, 2'd0, 4'b0000);

        // Coalesce: three edges on source 2 while busy with source 0
        for (int r = 0; r < 3; r++) begin
            irq[2] = 1'b1;
            step(2);
            irq[2] = 1'b0;
            step(2);
        end
        step(3);
        check_out("coal_pend", 1'b0, 1'b1, 2'd0, 4'b0100);
        // Raising source 2 together with eoi lands its edge exactly in FIRE of source 2
        eoi    = 1'b1;
        irq[2] = 1'b1;
        step(1);
        eoi = 1'b0;
        check_out("coal_idle", 1'b0, 1'b0, 2'd0, 4'b0100);
        step(1);
        check_out("coal_fire", 1'b1, 1'b0, 2'd2, 4'b0100);
        step(1);
        check_out("repend_svc", 1'b0, 1'b1, 2'd2, 4'b0100);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        check_out("repend_idle", 1'b0, 1'b0, 2'd2, 4'b0100);
        step(1);
        check_out("repend_fire", 1'b1, 1'b0, 2'd2, 4'b0100);
        step(1);
        check_out("repend_done", 1'b0, 1'b1, 2'd2, 4'b0000);

        // Reset during SERVICE with two bits pending
        irq = 4'b0000;
        step(3);
        irq = 4'b1010;
        step(3);
        check_out("rst_pre", 1'b0, 1'b1, 2'd2, 4'b1010);
        #2;
        rst = 1'b1;
        irq = 4'b0000;
        #1;
        check_out("rst_async", 1'b0, 1'b0, 2'd0, 4'b0000);
        step(2);
        rst = 1'b0;
        step(10);
        check_out("rst_after", 1'b0, 1'b0, 2'd0, 4'b0000);

        // Stray eoi in IDLE, then normal dispatch latency
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        check_out("stray_eoi", 1'b0, 1'b0, 2'd0, 4'b0000);
        irq = 4'b0100;
        step(3);
        check_out("stray_pend", 1'b0, 1'b0, 2'd0, 4'b0100);
        step(1);
        check_out("stray_fire", 1'b1, 1'b0, 2'd2, 4'b0100);
        step(1);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) irq[k] = ~irq[k];
            end
            if ($urandom_range(0, 15) == 0) mask = N'($urandom);
            eoi = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check_out("rand_rst", 1'b0, 1'b0, 2'd0, 4'b0000);
                step(1);
                rst = 1'b0;
            end
            step(1);
        end

        eoi = 1'b0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
